axis_test_pattern_gen: RTL

Video test-pattern source that produces an AXI-Stream raster with start-of-frame on `tuser[0]` and end-of-line on `tlast`. It sits directly upstream of the frame-rate/geometry monitor and feeds that stage's input stream. Frames have a known size, pattern and inter-frame gap, so the monitor's frame, line, pixel and FPS counts can be checked against exact expected values.

---
 rtl/axis_test_pattern_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axis_test_pattern_gen.sv
// AXI-Stream video test-pattern source: raster of WxH pixels, SOF on tuser[0], EOL on tlast.
// Optional inter-frame idle gap is built only when TPG_FRAME_GAP_EN is defined.
module axis_test_pattern_gen #(
   parameter int AXIS_DATA_WIDTH      = 8,
   parameter int AXIS_DATA_USER_WIDTH = 1,
   parameter int IMG_WIDTH_MAX        = 16,
   parameter int IMG_HEIGHT_MAX       = 16
) (
   input  logic                            i_axi_clk,
   input  logic                            i_axi_rst,
   input  logic                            i_enable,
   input  logic [IMG_WIDTH_MAX-1:0]        i_width,
   input  logic [IMG_HEIGHT_MAX-1:0]       i_height,
   input  logic [1:0]                      i_pattern,
   input  logic [31:0]                     i_frame_gap,
   output logic [AXIS_DATA_USER_WIDTH-1:0] o_axis_out_tuser,
   output logic                            o_axis_out_tvalid,
   input  logic                            i_axis_out_tready,
   output logic                            o_axis_out_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]      o_axis_out_tdata,
   output logic [31:0]                     o_frame_count,
   output logic                            o_busy
);

   localparam int WH_W   = (IMG_WIDTH_MAX > IMG_HEIGHT_MAX) ? IMG_WIDTH_MAX : IMG_HEIGHT_MAX;
   localparam int WHD_W  = (WH_W > AXIS_DATA_WIDTH) ? WH_W : AXIS_DATA_WIDTH;
   localparam int FULL_W = (WHD_W > 32) ? WHD_W : 32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1
`ifdef TPG_FRAME_GAP_EN
      , S_GAP  = 2'd2
`endif
   } state_t;

   state_t                     state_reg, state_next;
   logic [IMG_WIDTH_MAX-1:0]   x_reg, x_next, width_reg, width_next;
   logic [IMG_HEIGHT_MAX-1:0]  y_reg, y_next, height_reg, height_next;
   logic [1:0]                 pattern_reg, pattern_next;
   logic [31:0]                frame_count_reg, frame_count_next;
   logic                       tvalid_reg, tvalid_next;
   logic                       tuser_reg, tuser_next;
   logic                       tlast_reg, tlast_next;
   logic [AXIS_DATA_WIDTH-1:0] tdata_reg, tdata_next;
`ifdef TPG_FRAME_GAP_EN
   logic [31:0]                gap_reg, gap_next;
   logic [31:0]                gap_cnt_reg, gap_cnt_next;
`else
   logic                       unused_frame_gap;
   assign unused_frame_gap = ^i_frame_gap;
`endif

   logic              accept, start_ok, start_frame, last_x, last_pix;
   logic [FULL_W-1:0] xf, yf, pix_full;

   always_comb begin
      state_next       = state_reg;
      x_next           = x_reg;
      y_next           = y_reg;
      width_next       = width_reg;
      height_next      = height_reg;
      pattern_next     = pattern_reg;
      frame_count_next = frame_count_reg;
`ifdef TPG_FRAME_GAP_EN
      gap_next         = gap_reg;
      gap_cnt_next     = gap_cnt_reg;
`endif
      start_frame      = 1'b0;
      accept           = tvalid_reg & i_axis_out_tready;
      start_ok         = i_enable && (i_width != '0) && (i_height != '0);
      last_x           = (x_reg == width_reg - 1'b1);
      last_pix         = last_x && (y_reg == height_reg - 1'b1);

      case (state_reg)
         S_IDLE: begin
            if (start_ok) start_frame = 1'b1;
         end
         S_ACTIVE: begin
            if (accept) begin
               if (last_pix) begin
                  frame_count_next = frame_count_reg + 32'd1;
`ifdef TPG_FRAME_GAP_EN
                  if (gap_reg != 32'd0) begin
                     state_next   = S_GAP;
                     gap_cnt_next = gap_reg;
                  end else
`endif
                  if (start_ok) start_frame = 1'b1;
                  else          state_next  = S_IDLE;
               end else if (last_x) begin
                  x_next = '0;
                  y_next = y_reg + 1'b1;
               end else begin
                  x_next = x_reg + 1'b1;
               end
            end
         end
`ifdef TPG_FRAME_GAP_EN
         S_GAP: begin
            // Leaving on count==1 gives exactly G idle cycles after the last accept
            if (gap_cnt_reg == 32'd1) begin
               if (start_ok) start_frame = 1'b1;
               else          state_next  = S_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg - 32'd1;
            end
         end
`endif
         default: state_next = S_IDLE;
      endcase

      if (start_frame) begin
         state_next   = S_ACTIVE;
         width_next   = i_width;
         height_next  = i_height;
         pattern_next = i_pattern;
         x_next       = '0;
         y_next       = '0;
`ifdef TPG_FRAME_GAP_EN
         gap_next     = i_frame_gap;
`endif
      end

      // Beat registers are loaded from the next pixel so outputs stay registered
      xf = FULL_W'(x_next);
      yf = FULL_W'(y_next);
      case (pattern_next)
         2'd0:    pix_full = xf;
         2'd1:    pix_full = yf;
         2'd2:    pix_full = (xf[3] ^ yf[3]) ? '1 : '0;
         default: pix_full = FULL_W'(frame_count_next);
      endcase

      tvalid_next = (state_next == S_ACTIVE);
      tuser_next  = tvalid_next && (x_next == '0) && (y_next == '0);
      tlast_next  = tvalid_next && (x_next == width_next - 1'b1);
      tdata_next  = tvalid_next ? AXIS_DATA_WIDTH'(pix_full) : '0;
   end

   always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
      if (!i_axi_rst) begin
         state_reg       <= S_IDLE;
         x_reg           <= '0;
         y_reg           <= '0;
         width_reg       <= '0;
         height_reg      <= '0;
         pattern_reg     <= '0;
         frame_count_reg <= '0;
         tvalid_reg      <= 1'b0;
         tuser_reg       <= 1'b0;
         tlast_reg       <= 1'b0;
         tdata_reg       <= '0;
`ifdef TPG_FRAME_GAP_EN
         gap_reg         <= '0;
         gap_cnt_reg     <= '0;
`endif
      end else begin
         state_reg       <= state_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         width_reg       <= width_next;
         height_reg      <= height_next;
         pattern_reg     <= pattern_next;
         frame_count_reg <= frame_count_next;
         tvalid_reg      <= tvalid_next;
         tuser_reg       <= tuser_next;
         tlast_reg       <= tlast_next;
         tdata_reg       <= tdata_next;
`ifdef TPG_FRAME_GAP_EN
         gap_reg         <= gap_next;
         gap_cnt_reg     <= gap_cnt_next;
`endif
      end
   end

   always_comb begin
      o_axis_out_tuser    = '0;
      o_axis_out_tuser[0] = tuser_reg;
   end

   assign o_axis_out_tvalid = tvalid_reg;
   assign o_axis_out_tlast  = tlast_reg;
   assign o_axis_out_tdata  = tdata_reg;
   assign o_frame_count     = frame_count_reg;
   assign o_busy            = (state_reg != S_IDLE);

endmodule
